// File: rtl/writeback_regfile_pkg.sv
// Shared constants and the WB stage register layout for the writeback/regfile slice.
package writeback_regfile_pkg;
   localparam int DATA_W     = 32;
   localparam int REG_ADDR_W = 5;
   localparam int NUM_REGS   = 32;
   localparam int WBCNT_W    = 16;
   localparam logic [REG_ADDR_W-1:0] ZERO_REG = '0;

   typedef struct packed {
      logic                  wreg;
      logic                  m2reg;
      logic [REG_ADDR_W-1:0] dest;
      logic [DATA_W-1:0]     alu;
      logic [DATA_W-1:0]     dm;
   } wb_stage_t;
endpackage

// File: rtl/regfile_core.sv
// 32x32 register file: one write port, two combinational read ports with write-through bypass.
module regfile_core
   import writeback_regfile_pkg::*;
(
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  we,
   input  logic [REG_ADDR_W-1:0] waddr,
   input  logic [DATA_W-1:0]     wdata,
   input  logic [REG_ADDR_W-1:0] rs,
   input  logic [REG_ADDR_W-1:0] rt,
   output logic [DATA_W-1:0]     qa,
   output logic [DATA_W-1:0]     qb
);
   logic [NUM_REGS-1:0][DATA_W-1:0] regs;
   logic                            commit;

   assign commit = we && (waddr != ZERO_REG);

   always_ff @(posedge clock) begin
      if (reset)
         regs <= '0;
      else if (commit)
         regs[waddr] <= wdata;
   end

   // Both ports share one read path so rs==rt always yields identical data.
   function automatic logic [DATA_W-1:0] rd(input logic [REG_ADDR_W-1:0] a);
      if (a == ZERO_REG)
         return '0;
      else if (commit && (a == waddr))
         return wdata;
      else
         return regs[a];
   endfunction

   assign qa = rd(rs);
   assign qb = rd(rt);
endmodule

// File: rtl/writeback_regfile.sv
// WB stage register, result mux and commit counter in front of the register file.
module writeback_regfile
   import writeback_regfile_pkg::*;
(
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  mwreg,
   input  logic                  mm2reg,
   input  logic [REG_ADDR_W-1:0] mmux,
   input  logic [DATA_W-1:0]     malu,
   input  logic [DATA_W-1:0]     mdm,
   input  logic [REG_ADDR_W-1:0] rs,
   input  logic [REG_ADDR_W-1:0] rt,
   output logic [DATA_W-1:0]     qa,
   output logic [DATA_W-1:0]     qb,
   output logic                  wwreg,
   output logic [REG_ADDR_W-1:0] wdest,
   output logic [DATA_W-1:0]     wdata,
   output logic [WBCNT_W-1:0]    wb_count
);
   wb_stage_t wb_q;
   logic      commit;

   always_ff @(posedge clock) begin
      if (reset)
         wb_q <= '0;
      else
         wb_q <= '{wreg: mwreg, m2reg: mm2reg, dest: mmux, alu: malu, dm: mdm};
   end

   assign wwreg  = wb_q.wreg;
   assign wdest  = wb_q.dest;
   assign wdata  = wb_q.m2reg ? wb_q.dm : wb_q.alu;
   assign commit = wwreg && (wdest != ZERO_REG);

   // Counter wraps silently at the top of its range.
   always_ff @(posedge clock) begin
      if (reset)
         wb_count <= '0;
      else if (commit)
         wb_count <= wb_count + 1'b1;
   end

   regfile_core u_core (
      .clock (clock),
      .reset (reset),
      .we    (wwreg),
      .waddr (wdest),
      .wdata (wdata),
      .rs    (rs),
      .rt    (rt),
      .qa    (qa),
      .qb    (qb)
   );
endmodule

// File: tb/tb_writeback_regfile.sv
// Directed bench: WB outputs checked through an expectation queue, reads checked against constants.
module tb_writeback_regfile;
   logic        clock = 1'b0;
   logic        reset;
   logic        mwreg, mm2reg;
   logic [4:0]  mmux;
   logic [31:0] malu, mdm;
   logic [4:0]  rs, rt;
   logic [31:0] qa, qb;
   logic        wwreg;
   logic [4:0]  wdest;
   logic [31:0] wdata;
   logic [15:0] wb_count;

   typedef struct {
      logic        wreg;
      logic [4:0]  dest;
      logic [31:0] data;
   } exp_t;

   exp_t sb[$];
   int   checks = 0;
   int   errors = 0;

   writeback_regfile dut (
      .clock(clock), .reset(reset), .mwreg(mwreg), .mm2reg(mm2reg), .mmux(mmux),
      .malu(malu), .mdm(mdm), .rs(rs), .rt(rt), .qa(qa), .qb(qb),
      .wwreg(wwreg), .wdest(wdest), .wdata(wdata), .wb_count(wb_count)
   );

   always #5 clock = ~clock;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Present a MEM-stage instruction and queue what WB must show after the next edge.
   task automatic drive(input logic w, input logic m2r, input logic [4:0] d,
                        input logic [31:0] alu, input logic [31:0] dm);
      exp_t e;
      mwreg = w; mm2reg = m2r; mmux = d; malu = alu; mdm = dm;
      e.wreg = w; e.dest = d; e.data = m2r ? dm : alu;
      sb.push_back(e);
   endtask

   // Reset on the coming edge: anything queued for that edge is flushed.
   task automatic drive_reset();
      exp_t e;
      reset = 1'b1;
      e.wreg = 1'b0; e.dest = '0; e.data = '0;
      sb.delete();
      sb.push_back(e);
   endtask

   task automatic tick();
      exp_t e;
      @(posedge clock);
      #1;
      if (sb.size() == 0) begin
         checks++;
         errors++;
         $error("FAIL sb_empty: observed no expectation expected one queued");
      end else begin
         e = sb.pop_front();
         chk("wwreg", {31'b0, wwreg}, {31'b0, e.wreg});
         chk("wdest", {27'b0, wdest}, {27'b0, e.dest});
         chk("wdata", wdata, e.data);
      end
   endtask

   task automatic rd(input logic [4:0] a, input logic [4:0] b);
      rs = a; rt = b;
      #1;
   endtask

   initial begin
      reset = 1'b0; rs = '0; rt = '0;
      drive(1'b0, 1'b0, 5'd0, 32'h0, 32'h0);
      // Reset for two cycles, then all registers read zero.
      drive_reset(); tick();
      drive_reset(); tick();
      reset = 1'b0;
      drive(1'b0, 1'b0, 5'd0, 32'h0, 32'h0);
      for (int i = 0; i < 32; i++) begin
         rd(5'(i), 5'(31 - i));
         chk("rst_qa", qa, 32'h0);
         chk("rst_qb", qb, 32'h0);
      end
      chk("rst_cnt", {16'b0, wb_count}, 32'h0);
      chk("rst_wwreg", {31'b0, wwreg}, 32'h0);
      tick();

      // Load: memory data selected, bypass visible in the WB cycle.
      drive(1'b1, 1'b1, 5'd2, 32'h4, 32'hA00000AA);
      tick();
      rd(5'd2, 5'd0);
      chk("load_bypass_qa", qa, 32'hA00000AA);
      chk("load_qb_r0", qb, 32'h0);
      drive(1'b0, 1'b0, 5'd0, 32'h0, 32'h0);
      tick();
      rd(5'd2, 5'd2);
      chk("load_store_qa", qa, 32'hA00000AA);
      chk("load_store_qb", qb, 32'hA00000AA);
      chk("load_cnt", {16'b0, wb_count}, 32'd1);

      // ALU result selected over memory data.
      drive(1'b1, 1'b0, 5'd5, 32'h12345678, 32'hDEADBEEF);
      tick();
      drive(1'b0, 1'b1, 5'd5, 32'h0, 32'h0);
      tick();
      rd(5'd5, 5'd5);
      chk("alu_qa", qa, 32'h12345678);
      chk("alu_qb", qb, 32'h12345678);
      chk("alu_cnt", {16'b0, wb_count}, 32'd2);

      // Writes to register 0 are dropped and never bypassed.
      drive(1'b1, 1'b0, 5'd0, 32'hFFFFFFFF, 32'h0);
      tick();
      rd(5'd0, 5'd0);
      chk("r0_bypass_qa", qa, 32'h0);
      chk("r0_bypass_qb", qb, 32'h0);
      drive(1'b0, 1'b0, 5'd0, 32'h0, 32'h0);
      tick();
      rd(5'd0, 5'd5);
      chk("r0_qa", qa, 32'h0);
      chk("r0_other_qb", qb, 32'h12345678);
      chk("r0_cnt", {16'b0, wb_count}, 32'd2);

      // Back-to-back writes to one register with rs==rt.
      rd(5'd3, 5'd3);
      drive(1'b1, 1'b0, 5'd3, 32'h11, 32'h0);
      tick();
      chk("b2b1_qa", qa, 32'h11);
      chk("b2b1_qb", qb, 32'h11);
      drive(1'b1, 1'b0, 5'd3, 32'h22, 32'h0);
      tick();
      chk("b2b2_qa", qa, 32'h22);
      chk("b2b2_qb", qb, 32'h22);
      drive(1'b0, 1'b0, 5'd0, 32'h0, 32'h0);
      tick();
      chk("b2b3_qa", qa, 32'h22);
      chk("b2b3_qb", qb, 32'h22);
      chk("b2b_cnt", {16'b0, wb_count}, 32'd4);
      rd(5'd3, 5'd5);
      chk("split_qa", qa, 32'h22);
      chk("split_qb", qb, 32'h12345678);

      // Start the wrap run from a cleared counter.
      drive_reset(); tick();
      chk("mid_rst_cnt", {16'b0, wb_count}, 32'h0);
      rd(5'd3, 5'd2);
      chk("rst_hold_qa", qa, 32'h0);
      chk("rst_hold_qb", qb, 32'h0);
      reset = 1'b0;
      for (int i = 0; i < 65536; i++) begin
         drive(1'b1, 1'b0, 5'd1, 32'(i), 32'h0);
         tick();
      end
      chk("pre_wrap_cnt", {16'b0, wb_count}, 32'h0000FFFF);
      drive(1'b1, 1'b0, 5'd4, 32'h99, 32'h0);
      tick();
      chk("wrap_cnt", {16'b0, wb_count}, 32'h0);
      rd(5'd1, 5'd4);
      chk("wrap_r1", qa, 32'h0000FFFF);
      chk("pend_bypass_r4", qb, 32'h99);

      // Reset wins over the write pending in WB and the one at MEM.
      drive(1'b1, 1'b0, 5'd4, 32'h99, 32'h0);
      drive_reset();
      tick();
      rd(5'd4, 5'd1);
      chk("rst_r4", qa, 32'h0);
      chk("rst_r1", qb, 32'h0);
      chk("rst_cnt2", {16'b0, wb_count}, 32'h0);
      reset = 1'b0;
      drive(1'b0, 1'b0, 5'd0, 32'h0, 32'h0);
      tick();
      chk("post_rst_r4", qa, 32'h0);
      chk("post_rst_cnt", {16'b0, wb_count}, 32'h0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/writeback_regfile.md
WRITEBACK_REGFILE -- requirements
Module: writeback_regfile

Interface
REQ-001 The module SHALL have one clock and synchronous, active-high reset; all state SHALL change only on the rising edge of clock.
REQ-002 Port: clock  in  1  sole clock; every sequential element SHALL be rising-edge triggered.
REQ-003 Port: reset  in  1  synchronous, active-high reset.
REQ-004 Port: mwreg  in  1  MEM-stage register-write enable.
REQ-005 Port: mm2reg  in  1  MEM-stage select; 1 SHALL select memory data, 0 SHALL select ALU result.
REQ-006 Port: mmux  in  5  MEM-stage destination register number.
REQ-007 Port: malu  in  32  MEM-stage ALU result.
REQ-008 Port: mdm  in  32  MEM-stage data-memory read data.
REQ-009 Port: rs  in  5  ID-stage read address A.
REQ-010 Port: rt  in  5  ID-stage read address B.
REQ-011 Port: qa  out  32  read data for rs.
REQ-012 Port: qb  out  32  read data for rt.
REQ-013 Port: wwreg  out  1  WB-stage write enable, registered.
REQ-014 Port: wdest  out  5  WB-stage destination register, registered.
REQ-015 Port: wdata  out  32  WB-stage selected write data.
REQ-016 Port: wb_count  out  16  number of committed register writes.

Function
REQ-017 The WB stage register SHALL capture mwreg, mm2reg, mmux, malu and mdm on each rising clock edge when reset is 0, giving 1-cycle latency from MEM inputs to WB outputs.
REQ-018 wdata SHALL be the registered mdm when the registered m2reg is 1, else the registered malu; this selection SHALL be combinational from the stage register.
REQ-019 The module SHALL hold 32 registers of 32 bits each.
REQ-020 On a rising edge with wwreg=1 and wdest!=0, the module SHALL write wdata into register wdest.
REQ-021 Register 0 SHALL always read 0x00000000; writes with wdest=0 SHALL be discarded.
REQ-022 qa and qb SHALL be combinational reads of rs and rt.
REQ-023 Write-through bypass: when wwreg=1, wdest!=0 and rs==wdest, qa SHALL equal wdata in the same cycle; qb SHALL behave identically for rt.
REQ-024 When rs==rt, qa and qb SHALL be identical, including under bypass.
REQ-025 wb_count SHALL increment by 1 on each edge where a write commits per REQ-020.
REQ-026 wb_count SHALL not increment for discarded writes to register 0.
REQ-027 wb_count SHALL wrap from 0xFFFF to 0x0000 with no flag.
REQ-028 The module SHALL contain no negedge logic and no initial blocks; defined state SHALL come from reset only.

Reset
REQ-029 On a rising edge with reset=1, the module SHALL clear all 32 registers, the WB stage register and wb_count to 0; after that edge wwreg=0, wdest=0, wdata=0, wb_count=0.
REQ-030 Reset SHALL take priority over a write pending on the same edge: the write is lost and wb_count stays 0.
REQ-031 Reset asserted mid-stream SHALL flush the in-flight WB instruction; MEM inputs presented on the reset edge SHALL not be captured.
REQ-032 While reset=1, qa and qb SHALL read 0 after the first reset edge.

Structure
REQ-033 A shared package SHALL define the constants DATA_W=32, REG_ADDR_W=5, NUM_REGS=32, WBCNT_W=16 and ZERO_REG=0.
REQ-034 Storage, the write port and the bypass SHALL be a single sub-module named regfile_core; the WB stage register, the data mux and wb_count SHALL reside in the top module.

Verification
REQ-035 Reset scenario: assert reset 2 cycles, then release -> qa=qb=0 for rs=rt=0..31, wb_count=0 and wwreg=0.
REQ-036 Load scenario: mwreg=1, mm2reg=1, mmux=2, mdm=0xA00000AA, malu=0x4, then one edge -> wdata=0xA00000AA and rs=2 gives qa=0xA00000AA in that cycle via bypass. After the next edge, with mwreg=0 applied, qa=0xA00000AA from storage and wb_count=1.
REQ-037 ALU scenario: mwreg=1, mm2reg=0, mmux=5, malu=0x12345678, mdm=0xDEADBEEF -> register 5 = 0x12345678.
REQ-038 R0 scenario: mwreg=1, mmux=0, malu=0xFFFFFFFF -> rs=0 gives qa=0, no bypass occurs and wb_count is unchanged.
REQ-039 Back-to-back scenario: writes to register 3 of 0x11 then 0x22 on consecutive cycles, with rs=rt=3 -> qa=qb=0x11 then 0x22 each cycle with no stale value, and wb_count=2.
REQ-040 Wrap-and-reset scenario: commit 65536 writes to register 1 -> wb_count=0x0000; then assert reset on an edge with a pending write to register 4 (malu=0x99) -> register 4 = 0 and wb_count=0.
